// File: rtl/mmio_output_bank_if.sv
// mmio_output_bank_if: LSU-side store/read-back bus of the I/O output register bank
interface mmio_output_bank_if;
  logic [31:0] i_io_addr;
  logic [31:0] i_st_data;
  logic [2:0]  i_funct3;
  logic        i_io_wren;
  logic        i_io_rden;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_err;
  modport master (output i_io_addr, i_st_data, i_funct3, i_io_wren, i_io_rden,
                  input o_rd_data, o_rd_valid, o_err);
  modport slave (input i_io_addr, i_st_data, i_funct3, i_io_wren, i_io_rden,
                 output o_rd_data, o_rd_valid, o_err);
endinterface

// File: rtl/mmio_output_bank.sv
// mmio_output_bank: memory-mapped output channels with sub-word stores, set/clear/toggle aliases and read-back
module mmio_output_bank #(
  parameter int NUM_CH = 5,
  parameter int CH_ADDR_LSB = 12,
  parameter logic [NUM_CH*32-1:0] RESET_VALS = {32'h0, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h0, 32'h0}
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  mmio_output_bank_if.slave      bus,
  output logic [NUM_CH*32-1:0]   o_ch_data,
  output logic [NUM_CH-1:0]      o_changed
);
  logic [NUM_CH*32-1:0] ch_d, ch_q;
  logic [NUM_CH-1:0] changed_d, changed_q;
  logic [31:0] rd_data_d, rd_data_q, m, dm, cur, nv;
  logic rd_valid_d, rd_valid_q, err_d, err_q;
  logic [3:0] ch;
  logic [1:0] op, off;
  logic [2:0] f3;
  logic size_ok, ch_ok, wr_ok;
  logic addr_unused;
  assign addr_unused = ^{bus.i_io_addr[31:CH_ADDR_LSB+4], bus.i_io_addr[CH_ADDR_LSB-1:4]};
  always_comb begin
    ch = bus.i_io_addr[CH_ADDR_LSB+3 -: 4];
    op = bus.i_io_addr[3:2];
    off = bus.i_io_addr[1:0];
    f3 = bus.i_funct3;
    ch_ok = {1'b0, ch} < 5'(NUM_CH);
    size_ok = f3 == 3'b000 || (f3 == 3'b001 && !off[0]) || (f3 == 3'b010 && off == 2'b00);
    wr_ok = bus.i_io_wren && size_ok && ch_ok;
    m = f3 == 3'b000 ? 32'hFF << {off, 3'b000} : f3 == 3'b001 ? (off[1] ? 32'hFFFF0000 : 32'h0000FFFF) : 32'hFFFFFFFF;
    dm = m & (f3 == 3'b000 ? {4{bus.i_st_data[7:0]}} : f3 == 3'b001 ? {2{bus.i_st_data[15:0]}} : bus.i_st_data);
    cur = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (4'(k) == ch) cur = ch_q[k*32 +: 32];
    nv = op == 2'b00 ? (cur & ~m) | dm : op == 2'b01 ? cur | dm : op == 2'b10 ? cur & ~dm : cur ^ dm;
    ch_d = ch_q;
    changed_d = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (wr_ok && 4'(k) == ch) begin
        ch_d[k*32 +: 32] = nv;
        changed_d[k] = nv != cur;
      end
    err_d = bus.i_io_wren && !(size_ok && ch_ok);
    rd_valid_d = bus.i_io_rden;
    // cur is the pre-write value, so a same-cycle read sees the old contents
    rd_data_d = bus.i_io_rden ? (ch_ok ? cur : 32'h0) : rd_data_q;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      ch_q <= RESET_VALS;
      changed_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ch_q <= ch_d;
      changed_q <= changed_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q <= err_d;
    end
  assign o_ch_data = ch_q;
  assign o_changed = changed_q;
  assign bus.o_rd_data = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_err = err_q;
endmodule

// File: tb/tb_mmio_output_bank.sv
// tb_mmio_output_bank: directed and randomized checks against a byte-lane reference model
module tb_mmio_output_bank;
  localparam logic [159:0] RV = {32'h0, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h0, 32'h0};
  logic i_clk = 1'b0, i_reset = 1'b0;
  logic [159:0] o_ch_data;
  logic [4:0] o_changed;
  int checks = 0, errors = 0;
  mmio_output_bank_if bus();
  mmio_output_bank #(.NUM_CH(5), .CH_ADDR_LSB(12), .RESET_VALS(RV)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus), .o_ch_data(o_ch_data), .o_changed(o_changed));
  always #5 i_clk = ~i_clk;

  logic [31:0] mdl [5];
  logic [4:0] ex_chg;
  logic ex_err, ex_rdv;
  logic [31:0] ex_rd;

  function automatic logic [159:0] packed_mdl();
    return {mdl[4], mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic model_reset();
    mdl[0] = 32'h0; mdl[1] = 32'h0; mdl[2] = 32'h7F7F7F7F; mdl[3] = 32'h7F7F7F7F; mdl[4] = 32'h0;
    ex_chg = '0; ex_err = 1'b0; ex_rdv = 1'b0; ex_rd = '0;
  endtask

  task automatic model_cycle(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3, input logic we, input logic re);
    int c, off, op;
    logic legal, cov;
    logic [31:0] old, nw;
    logic [7:0] db;
    c = int'(a[15:12]); off = int'(a[1:0]); op = int'(a[3:2]);
    if (re) ex_rd = (c < 5) ? mdl[c] : 32'h0;
    ex_rdv = re;
    legal = c < 5 && (f3 == 0 || (f3 == 1 && off % 2 == 0) || (f3 == 2 && off == 0));
    ex_err = we && !legal;
    ex_chg = '0;
    if (we && legal) begin
      old = mdl[c];
      nw = old;
      for (int b = 0; b < 4; b++) begin
        cov = f3 == 0 ? b == off : f3 == 1 ? b / 2 == off / 2 : 1'b1;
        db = f3 == 0 ? d[7:0] : f3 == 1 ? d[(b % 2) * 8 +: 8] : d[b * 8 +: 8];
        if (cov)
          case (op)
            0: nw[b*8 +: 8] = db;
            1: nw[b*8 +: 8] = nw[b*8 +: 8] | db;
            2: nw[b*8 +: 8] = nw[b*8 +: 8] & ~db;
            default: nw[b*8 +: 8] = nw[b*8 +: 8] ^ db;
          endcase
      end
      mdl[c] = nw;
      ex_chg[c] = nw != old;
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3, input logic we, input logic re);
    @(negedge i_clk);
    bus.i_io_addr = a; bus.i_st_data = d; bus.i_funct3 = f3; bus.i_io_wren = we; bus.i_io_rden = re;
    model_cycle(a, d, f3, we, re);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    bus.i_io_wren = 1'b0; bus.i_io_rden = 1'b0;
    i_reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_ch_data !== RV) begin errors++; $display("FAIL reset_ch_data got %h exp %h", o_ch_data, RV); end
    checks++; if (o_changed !== 5'b0) begin errors++; $display("FAIL reset_changed got %h exp 0", o_changed); end
    checks++; if (bus.o_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", bus.o_rd_data); end
    checks++; if (bus.o_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.o_rd_valid); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.o_err); end
    release_reset();
    drive(32'h2000, 32'h0, 3'b010, 1'b0, 1'b1);
    checks++; if (bus.o_rd_valid !== 1'b1) begin errors++; $display("FAIL rd_ch2_valid got %b exp 1", bus.o_rd_valid); end
    checks++; if (bus.o_rd_data !== 32'h7F7F7F7F) begin errors++; $display("FAIL rd_ch2_data got %h exp 7f7f7f7f", bus.o_rd_data); end
    checks++; if (o_changed !== 5'b0) begin errors++; $display("FAIL rd_ch2_changed got %h exp 0", o_changed); end
  endtask

  task automatic test_byte_half();
    drive(32'h0003, 32'h000000A5, 3'b000, 1'b1, 1'b0);
    checks++; if (o_ch_data[31:0] !== 32'hA5000000) begin errors++; $display("FAIL sb_ch0 got %h exp a5000000", o_ch_data[31:0]); end
    checks++; if (o_changed !== 5'b00001) begin errors++; $display("FAIL sb_changed got %h exp 01", o_changed); end
    idle();
    checks++; if (o_changed !== 5'b0) begin errors++; $display("FAIL sb_changed_once got %h exp 0", o_changed); end
    drive(32'h0002, 32'h00001234, 3'b001, 1'b1, 1'b0);
    checks++; if (o_ch_data[31:0] !== 32'h12340000) begin errors++; $display("FAIL sh_ch0 got %h exp 12340000", o_ch_data[31:0]); end
  endtask

  task automatic test_aliases();
    logic [31:0] addrs [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    logic [31:0] dats [4] = '{32'hFFFF0000, 32'h000000FF, 32'hFF000000, 32'h0000FFFF};
    logic [31:0] exps [4] = '{32'hFFFF0000, 32'hFFFF00FF, 32'h00FF00FF, 32'h00FFFF00};
    for (int i = 0; i < 4; i++) begin
      drive(addrs[i], dats[i], 3'b010, 1'b1, 1'b0);
      checks++; if (o_ch_data[63:32] !== exps[i]) begin errors++; $display("FAIL alias%0d_ch1 got %h exp %h", i, o_ch_data[63:32], exps[i]); end
      checks++; if (o_changed !== 5'b00010) begin errors++; $display("FAIL alias%0d_changed got %h exp 02", i, o_changed); end
    end
  endtask

  task automatic test_no_change();
    drive(32'h4000, 32'h1, 3'b010, 1'b1, 1'b0);
    drive(32'h4004, 32'h1, 3'b010, 1'b1, 1'b0);
    checks++; if (o_ch_data[159:128] !== 32'h1) begin errors++; $display("FAIL noop_ch4 got %h exp 1", o_ch_data[159:128]); end
    checks++; if (o_changed !== 5'b0) begin errors++; $display("FAIL noop_changed got %h exp 0", o_changed); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL noop_err got %b exp 0", bus.o_err); end
  endtask

  task automatic test_reject();
    logic [31:0] addrs [4] = '{32'h0002, 32'h0001, 32'h0000, 32'h5000};
    logic [2:0] f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
    for (int i = 0; i < 4; i++) begin
      drive(addrs[i], 32'hFFFFFFFF, f3s[i], 1'b1, 1'b0);
      checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL rej%0d_err got %b exp 1", i, bus.o_err); end
      checks++; if (o_ch_data !== packed_mdl()) begin errors++; $display("FAIL rej%0d_data got %h exp %h", i, o_ch_data, packed_mdl()); end
      checks++; if (o_changed !== 5'b0) begin errors++; $display("FAIL rej%0d_changed got %h exp 0", i, o_changed); end
    end
    idle();
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL rej_err_pulse got %b exp 0", bus.o_err); end
  endtask

  task automatic test_same_cycle();
    drive(32'h3000, 32'hDEADBEEF, 3'b010, 1'b1, 1'b1);
    checks++; if (bus.o_rd_data !== 32'h7F7F7F7F) begin errors++; $display("FAIL same_rd got %h exp 7f7f7f7f", bus.o_rd_data); end
    checks++; if (o_ch_data[127:96] !== 32'hDEADBEEF) begin errors++; $display("FAIL same_ch3 got %h exp deadbeef", o_ch_data[127:96]); end
    drive(32'h300C, 32'h0, 3'b000, 1'b0, 1'b1);
    checks++; if (bus.o_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL next_rd got %h exp deadbeef", bus.o_rd_data); end
    idle();
    checks++; if (bus.o_rd_valid !== 1'b0) begin errors++; $display("FAIL rdv_pulse got %b exp 0", bus.o_rd_valid); end
    checks++; if (bus.o_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got %h exp deadbeef", bus.o_rd_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive({16'h0, 4'h1, 8'h0, 2'($urandom_range(1, 3)), 2'(i)}, $urandom, 3'b000, 1'b1, 1'b0);
      checks++; if (o_ch_data !== packed_mdl()) begin errors++; $display("FAIL b2b%0d_data got %h exp %h", i, o_ch_data, packed_mdl()); end
      checks++; if (o_changed !== ex_chg) begin errors++; $display("FAIL b2b%0d_changed got %h exp %h", i, o_changed, ex_chg); end
    end
  endtask

  task automatic test_async_reset();
    drive(32'h0000, 32'h11223344, 3'b010, 1'b1, 1'b0);
    @(negedge i_clk);
    bus.i_io_addr = 32'h1000; bus.i_st_data = 32'hCAFEF00D; bus.i_funct3 = 3'b010;
    bus.i_io_wren = 1'b1; bus.i_io_rden = 1'b1;
    #2 i_reset = 1'b1;
    model_reset();
    #1;
    checks++; if (o_ch_data !== RV) begin errors++; $display("FAIL async_data got %h exp %h", o_ch_data, RV); end
    checks++; if (o_changed !== 5'b0) begin errors++; $display("FAIL async_changed got %h exp 0", o_changed); end
    @(posedge i_clk);
    #1;
    checks++; if (o_ch_data !== RV) begin errors++; $display("FAIL async_discard got %h exp %h", o_ch_data, RV); end
    checks++; if (bus.o_rd_valid !== 1'b0) begin errors++; $display("FAIL async_rdv got %b exp 0", bus.o_rd_valid); end
    @(negedge i_clk);
    bus.i_io_wren = 1'b0; bus.i_io_rden = 1'b0;
    i_reset = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0] f3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        checks++; if (o_ch_data !== RV) begin errors++; $display("FAIL rnd%0d_reset got %h exp %h", i, o_ch_data, RV); end
        release_reset();
      end
      a = $urandom;
      a[15:12] = 4'($urandom_range(0, 6));
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      drive(a, $urandom, f3, 1'($urandom), 1'($urandom));
      checks++; if (o_ch_data !== packed_mdl()) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", i, o_ch_data, packed_mdl()); end
      checks++; if (o_changed !== ex_chg) begin errors++; $display("FAIL rnd%0d_changed got %h exp %h", i, o_changed, ex_chg); end
      checks++; if (bus.o_err !== ex_err) begin errors++; $display("FAIL rnd%0d_err got %b exp %b", i, bus.o_err, ex_err); end
      checks++; if (bus.o_rd_valid !== ex_rdv) begin errors++; $display("FAIL rnd%0d_rdv got %b exp %b", i, bus.o_rd_valid, ex_rdv); end
      checks++; if (bus.o_rd_data !== ex_rd) begin errors++; $display("FAIL rnd%0d_rd got %h exp %h", i, bus.o_rd_data, ex_rd); end
    end
  endtask

  initial begin
    bus.i_io_addr = '0; bus.i_st_data = '0; bus.i_funct3 = '0; bus.i_io_wren = 1'b0; bus.i_io_rden = 1'b0;
    test_reset();
    test_byte_half();
    test_aliases();
    test_no_change();
    test_reject();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
